exec_sequencer: RTL and testbench

- Multi-cycle sequencer for the SIWO core.
- Takes the decoded control bundle from the instruction decoder and steps the datapath through FETCH/DECODE/EXEC/MEM/WB.
- Turns the decoder's level signals into single-cycle enable pulses for the PC, instruction register, ALU, register file and flag registers.
- Runs a req/ack handshake with data memory and keeps cycle and retired-instruction counters.

---
 rtl/exec_sequencer_pkg.sv | 25 ++
 rtl/exec_sequencer_sat_counter.sv | 25 ++
 rtl/exec_sequencer.sv | 159 +++++++++++++++
 tb/tb_exec_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the SIWO multi-cycle execution sequencer.
// Holds the state encoding, default counter/timeout sizes and state helpers.
// Pure definitions: no logic, no latency, no backpressure.
package exec_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_WB     = 3'd5,
        SEQ_HALT   = 3'd6,
        SEQ_ERR    = 3'd7
    } seq_state_t;

    localparam int SEQ_CNT_WIDTH   = 16;
    localparam int SEQ_MEM_TIMEOUT = 15;

    // States in which a start request is honoured (the sequencer is parked).
    function automatic logic seq_can_start(input seq_state_t s);
        return (s == SEQ_IDLE) || (s == SEQ_HALT) || (s == SEQ_ERR);
    endfunction

endpackage

// File: rtl/exec_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: count reflects clear/enable one clock after they are sampled.
// No backpressure: clear wins over enable, counting stops at all-ones.
module exec_sequencer_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Clear has priority; once all-ones the value is held so it stays readable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer: steps FETCH/DECODE/EXEC/MEM/WB and emits datapath enable pulses.
// Latency: 4 cycles per non-memory instruction, 5 + wait cycles per memory instruction.
// Backpressure: MEM holds mem_req until mem_ack; MEM_TIMEOUT cycles without ack parks in ERR.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH   = SEQ_CNT_WIDTH,
    parameter int MEM_TIMEOUT = SEQ_MEM_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 regWrite,
    input  logic                 memoryRead,
    input  logic                 memoryWrite,
    input  logic                 compare,
    input  logic                 overflow,
    input  logic                 mem_ack,
    output logic                 pc_clear,
    output logic                 insn_load,
    output logic                 alu_enable,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 reg_we,
    output logic                 cmp_we,
    output logic                 ovf_we,
    output logic                 pc_advance,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] insn_count
);

    // The timeout counter only has to reach MEM_TIMEOUT-1 before the ERR decision.
    localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    seq_state_t       state;
    logic [TMO_W-1:0] tmo_cnt;

    // pc_clear must land in the cycle start is accepted so the first FETCH already reads PC 0.
    assign pc_clear = start & ~reset & seq_can_start(state);

    // Single FSM; every output flop is loaded together with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SEQ_IDLE;
            tmo_cnt    <= '0;
            insn_load  <= 1'b0;
            alu_enable <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            reg_we     <= 1'b0;
            cmp_we     <= 1'b0;
            ovf_we     <= 1'b0;
            pc_advance <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            insn_load  <= 1'b0;
            alu_enable <= 1'b0;
            reg_we     <= 1'b0;
            cmp_we     <= 1'b0;
            ovf_we     <= 1'b0;
            pc_advance <= 1'b0;
            case (state)
                SEQ_IDLE, SEQ_HALT, SEQ_ERR: begin
                    if (start) begin
                        state     <= SEQ_FETCH;
                        insn_load <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                SEQ_FETCH: begin
                    state <= SEQ_DECODE;
                end
                SEQ_DECODE: begin
                    if (halt) begin
                        state <= SEQ_HALT;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state      <= SEQ_EXEC;
                        alu_enable <= 1'b1;
                    end
                end
                SEQ_EXEC: begin
                    if (memoryRead || memoryWrite) begin
                        state   <= SEQ_MEM;
                        tmo_cnt <= '0;
                        mem_req <= 1'b1;
                        mem_we  <= memoryWrite;
                    end else begin
                        state      <= SEQ_WB;
                        reg_we     <= regWrite;
                        cmp_we     <= compare;
                        ovf_we     <= overflow;
                        pc_advance <= 1'b1;
                    end
                end
                SEQ_MEM: begin
                    if (mem_ack) begin
                        state      <= SEQ_WB;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        reg_we     <= regWrite;
                        cmp_we     <= compare;
                        ovf_we     <= overflow;
                        pc_advance <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= SEQ_ERR;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                SEQ_WB: begin
                    state     <= SEQ_FETCH;
                    insn_load <= 1'b1;
                end
                default: begin
                    state   <= SEQ_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    error   <= 1'b0;
                end
            endcase
        end
    end

    // busy mirrors FETCH..WB, so it is exactly the cycle-count enable.
    exec_sequencer_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (pc_clear),
        .enable (busy),
        .count  (cycle_count)
    );

    // An instruction retires when it leaves WB; pc_advance marks the WB cycle.
    exec_sequencer_sat_counter #(.WIDTH(CNT_WIDTH)) u_insn_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (pc_clear),
        .enable (pc_advance),
        .count  (insn_count)
    );

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomised scoreboard bench for exec_sequencer with a program-level reference model.
// Driver plays decoder + data memory; monitor pops expectations on WB and on HALT/ERR entry.
// Counters are narrowed to 6 bits so saturation is reachable.
module tb_exec_sequencer;

    localparam int CW  = 6;
    localparam int TMO = 15;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset, start, halt, regWrite, memoryRead, memoryWrite, compare, overflow, mem_ack;
    logic pc_clear, insn_load, alu_enable, mem_req, mem_we, reg_we, cmp_we, ovf_we;
    logic pc_advance, busy, done, error;
    logic [CW-1:0] cycle_count, insn_count;

    always #5 clk = ~clk;

    exec_sequencer #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .regWrite(regWrite),
        .memoryRead(memoryRead), .memoryWrite(memoryWrite), .compare(compare),
        .overflow(overflow), .mem_ack(mem_ack), .pc_clear(pc_clear), .insn_load(insn_load),
        .alu_enable(alu_enable), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
        .cmp_we(cmp_we), .ovf_we(ovf_we), .pc_advance(pc_advance), .busy(busy),
        .done(done), .error(error), .cycle_count(cycle_count), .insn_count(insn_count)
    );

    // kind: 0 ALU, 1 load, 2 store, 3 halt; delay: MEM wait cycles before ack, -1 = never
    typedef struct {
        int kind; bit rw; bit cmp; bit ovf; int delay;
    } insn_t;

    typedef struct {
        bit is_end; bit is_err; bit rw; bit cmp; bit ovf;
        int cycles; int mreq; int mwe; int icnt; int ccnt; int busy_total;
    } exp_t;

    insn_t prog[$];
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    function automatic insn_t mk(input int kind, input bit rw, input bit cmp, input bit ovf, input int delay);
        insn_t x;
        x.kind = kind; x.rw = rw; x.cmp = cmp; x.ovf = ovf; x.delay = delay;
        return x;
    endfunction

    // Reference model: walk the program, charging 4 cycles per ALU op, 5+wait per memory op,
    // 2 for the halting fetch/decode and 3+TMO for a memory op that never gets an ack.
    task automatic model_push(input bit aborted);
        int retired = 0;
        int total = 0;
        foreach (prog[i]) begin
            exp_t e;
            e = '{default: 0};
            if (prog[i].kind == 3) begin
                total += 2;
                e.is_end = 1; e.ccnt = sat(total); e.icnt = sat(retired); e.busy_total = total;
                sb.push_back(e);
                return;
            end
            if (prog[i].kind != 0 && prog[i].delay < 0) begin
                if (aborted) return;
                total += 3 + TMO;
                e.is_end = 1; e.is_err = 1;
                e.ccnt = sat(total); e.icnt = sat(retired); e.busy_total = total;
                sb.push_back(e);
                return;
            end
            e.rw = prog[i].rw; e.cmp = prog[i].cmp; e.ovf = prog[i].ovf;
            e.cycles = (prog[i].kind == 0) ? 4 : 5 + prog[i].delay;
            e.mreq   = (prog[i].kind == 0) ? 0 : prog[i].delay + 1;
            e.mwe    = (prog[i].kind == 2) ? prog[i].delay + 1 : 0;
            e.icnt   = sat(retired);
            sb.push_back(e);
            retired++;
            total += e.cycles;
        end
    endtask

    // Plays decoder and data memory for the queued program; optionally resets mid-MEM.
    task automatic run_prog(input bit abort);
        int idx = 0;
        int mcyc = 0;
        int budget = 0;
        insn_t cur;
        cur = mk(0, 0, 0, 0, 0);
        model_push(abort);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (1) begin
            if (done || error) break;
            if (budget > 3000) begin
                check("program_timeout", budget, 0);
                break;
            end
            if (insn_load && idx < prog.size()) begin
                cur = prog[idx]; idx++; mcyc = 0;
                regWrite    = cur.rw;
                compare     = cur.cmp;
                overflow    = cur.ovf;
                memoryRead  = (cur.kind == 1);
                memoryWrite = (cur.kind == 2);
                halt        = (cur.kind == 3);
            end
            if (mem_req) begin
                mcyc++;
                if (abort && mcyc == 3) begin
                    #3 reset = 1'b1;
                    #1;
                    check("reset_midmem_mem_req", mem_req, 0);
                    check("reset_midmem_outputs",
                          {pc_clear, insn_load, alu_enable, mem_req, mem_we, reg_we, cmp_we,
                           ovf_we, pc_advance, busy, done, error}, 0);
                    start = 1'b0; mem_ack = 1'b0;
                    repeat (2) @(negedge clk);
                    reset = 1'b0;
                    #1;
                    check("reset_midmem_cycle_count", cycle_count, 0);
                    check("reset_midmem_insn_count", insn_count, 0);
                    return;
                end
                mem_ack = (cur.delay >= 0) && (mcyc == cur.delay + 1);
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            start = busy && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        mem_ack = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic gen_random();
        int n;
        n = $urandom_range(1, 10);
        prog.delete();
        for (int i = 0; i < n; i++) begin
            int r;
            int d;
            r = $urandom_range(0, 3);
            d = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 4);
            if (r <= 1)      prog.push_back(mk(0, 1'($urandom), 1'($urandom), 1'($urandom), 0));
            else if (r == 2) prog.push_back(mk(1, 1'b1, 1'b0, 1'b0, d));
            else             prog.push_back(mk(2, 1'b0, 1'b0, 1'b0, d));
        end
        prog.push_back(mk(3, 0, 0, 0, 0));
    endtask

    // Monitor: measures each instruction from insn_load to pc_advance and each run up to HALT/ERR.
    initial begin
        int icyc = 0, mreq = 0, mwe = 0, busy_tot = 0, pclr = 0;
        bit pdone = 0, perr = 0, first = 0;
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (reset) begin
                icyc = 0; mreq = 0; mwe = 0; busy_tot = 0; pclr = 0;
                pdone = 0; perr = 0; first = 0;
                continue;
            end
            if ((done && !pdone) || (error && !perr)) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_end: done=%0b error=%0b with no expectation queued", done, error);
                end else begin
                    e = sb.pop_front();
                    check("end_is_error", error, e.is_err);
                    check("end_done", done, !e.is_err);
                    check("end_cycle_count", cycle_count, e.ccnt);
                    check("end_insn_count", insn_count, e.icnt);
                    check("end_busy_cycles", busy_tot, e.busy_total);
                    check("end_pc_clear_pulses", pclr, 1);
                    check("end_mem_req_low", mem_req, 0);
                end
                pclr = 0;
            end
            pdone = done; perr = error;
            if (pc_clear) begin pclr++; busy_tot = 0; first = 1; end
            if (insn_load) begin
                if (first) begin
                    check("restart_cycle_count", cycle_count, 0);
                    check("restart_insn_count", insn_count, 0);
                    first = 0;
                end
                icyc = 0; mreq = 0; mwe = 0;
            end
            if (busy) begin icyc++; busy_tot++; end
            if (mem_req) mreq++;
            if (mem_we) mwe++;
            if (pc_advance) begin
                if (sb.size() == 0 || sb[0].is_end) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wb: pc_advance with no retire expectation queued");
                end else begin
                    e = sb.pop_front();
                    check("wb_reg_we", reg_we, e.rw);
                    check("wb_cmp_we", cmp_we, e.cmp);
                    check("wb_ovf_we", ovf_we, e.ovf);
                    check("wb_insn_cycles", icyc, e.cycles);
                    check("wb_mem_req_cycles", mreq, e.mreq);
                    check("wb_mem_we_cycles", mwe, e.mwe);
                    check("wb_insn_count", insn_count, e.icnt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b1; halt = 0; regWrite = 0; memoryRead = 0;
        memoryWrite = 0; compare = 0; overflow = 0; mem_ack = 0;
        #1;
        check("reset_outputs",
              {pc_clear, insn_load, alu_enable, mem_req, mem_we, reg_we, cmp_we,
               ovf_we, pc_advance, busy, done, error}, 0);
        check("reset_counters", {cycle_count, insn_count}, 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // three ALU ops then halt
        prog.delete();
        repeat (3) prog.push_back(mk(0, 1, 0, 0, 0));
        prog.push_back(mk(3, 0, 0, 0, 0));
        run_prog(0);

        // load waiting 3 cycles, store acked at once, compare, then halt
        prog.delete();
        prog.push_back(mk(1, 1, 0, 0, 3));
        prog.push_back(mk(2, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 1, 0, 0));
        prog.push_back(mk(0, 1, 0, 1, 0));
        prog.push_back(mk(3, 0, 0, 0, 0));
        run_prog(0);

        // memory op that is never acknowledged
        prog.delete();
        prog.push_back(mk(0, 1, 1, 1, 0));
        prog.push_back(mk(2, 0, 0, 0, -1));
        run_prog(0);

        // restart out of ERR
        prog.delete();
        prog.push_back(mk(1, 1, 0, 0, 1));
        prog.push_back(mk(3, 0, 0, 0, 0));
        run_prog(0);

        // reset while in MEM
        prog.delete();
        prog.push_back(mk(0, 1, 0, 0, 0));
        prog.push_back(mk(0, 0, 1, 0, 0));
        prog.push_back(mk(1, 1, 0, 0, -1));
        run_prog(1);

        for (int p = 0; p < 25; p++) begin
            gen_random();
            run_prog(0);
        end

        // long program to saturate both counters
        prog.delete();
        repeat (70) prog.push_back(mk(0, 1, 0, 0, 0));
        prog.push_back(mk(3, 0, 0, 0, 0));
        run_prog(0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
